vga_timing_gen: RTL

Parametrised VGA raster timing generator; successor to the fixed 640x480 controller. All four porch/sync/active intervals are generics per axis, sync polarity is selectable, and the pixel rate is an integer divide of `Clk` expressed as a clock-enable rather than a derived clock. All outputs are registered and mutually aligned. It feeds the pixel pipeline (`DrawX`/`DrawY`/`blank`) and the DAC/connector (`hs`/`vs`), and adds `en` gating plus frame and line strobes.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 55 +++++
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types, 640x480@60 default constants and the axis-total helper.
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  typedef enum logic {
    VGA_IDLE = 1'b0,
    VGA_RUN  = 1'b1
  } vga_state_e;

  localparam int unsigned VGA_H_ACTIVE = 32'd640;
  localparam int unsigned VGA_H_FP     = 32'd16;
  localparam int unsigned VGA_H_SYNC   = 32'd96;
  localparam int unsigned VGA_H_BP     = 32'd48;
  localparam int unsigned VGA_V_ACTIVE = 32'd480;
  localparam int unsigned VGA_V_FP     = 32'd10;
  localparam int unsigned VGA_V_SYNC   = 32'd2;
  localparam int unsigned VGA_V_BP     = 32'd33;

  localparam vga_axis_t VGA_H_AXIS_DEF = '{active: VGA_H_ACTIVE, fp: VGA_H_FP,
                                           sync: VGA_H_SYNC, bp: VGA_H_BP};

  function automatic int unsigned vga_total(input vga_axis_t ax);
    return ax.active + ax.fp + ax.sync + ax.bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with combinational sync/active/wrap decode of the
// registered position. The parent registers the decodes together with the position.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter vga_axis_t AXIS     = VGA_H_AXIS_DEF,
  parameter bit        SYNC_NEG = 1'b1,
  parameter int        CW       = 10
) (
  input  logic          clk_i,
  input  logic          step_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output logic          sync_o,
  output logic          active_o,
  output logic          wrap_o
);

  // One spare bit so window ends equal to 2**CW still compare correctly
  localparam int          CW1     = CW + 1;
  localparam logic [CW:0] LAST    = CW1'(vga_total(AXIS) - 32'd1);
  localparam logic [CW:0] ACT_HI  = CW1'(AXIS.active);
  localparam logic [CW:0] SYNC_LO = CW1'(AXIS.active + AXIS.fp);
  localparam logic [CW:0] SYNC_HI = CW1'(AXIS.active + AXIS.fp + AXIS.sync);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW:0]   count_x;

  assign count_x  = {1'b0, count_q};
  assign wrap_o   = (count_x == LAST);
  assign active_o = (count_x < ACT_HI);
  assign sync_o   = ((count_x >= SYNC_LO) && (count_x < SYNC_HI)) ^ SYNC_NEG;
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (step_i) begin
      if (wrap_o) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with clock-enable pixel strobe.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_NEG   = 1'b1,
  parameter bit          VS_NEG   = 1'b1,
  parameter int unsigned CLK_DIV  = 32'd2,
  parameter int          CW       = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          en,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          pixel_ce,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam vga_axis_t H_AXIS = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_axis_t V_AXIS = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int        DW       = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 32'd1);

  vga_state_e    state_q;
  logic [DW-1:0] div_q;
  logic [CW-1:0] drawx_q, drawy_q;
  logic          hs_q, vs_q, blank_q, pce_q, ls_q, fs_q;
  logic          origin_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic          first_q;
  logic [15:0]   fcnt_q;
`endif

  logic          step_s, clear_s, v_step_s;
  logic [CW-1:0] h_count_s, v_count_s;
  logic          h_sync_s, v_sync_s, h_act_s, v_act_s, h_wrap_s, v_wrap_s;

  always_comb begin
    step_s = 1'b0;
    if ((state_q == VGA_RUN) && en && !Reset) begin
      step_s = (div_q == DIV_LAST);
    end else begin
      step_s = 1'b0;
    end
  end

  assign clear_s  = Reset | ~en | (state_q == VGA_IDLE);
  assign v_step_s = step_s & h_wrap_s;

  vga_axis_counter #(.AXIS(H_AXIS), .SYNC_NEG(HS_NEG), .CW(CW)) u_h_cnt (
    .clk_i   (Clk),
    .step_i  (step_s),
    .clear_i (clear_s),
    .count_o (h_count_s),
    .sync_o  (h_sync_s),
    .active_o(h_act_s),
    .wrap_o  (h_wrap_s)
  );

  vga_axis_counter #(.AXIS(V_AXIS), .SYNC_NEG(VS_NEG), .CW(CW)) u_v_cnt (
    .clk_i   (Clk),
    .step_i  (v_step_s),
    .clear_i (clear_s),
    .count_o (v_count_s),
    .sync_o  (v_sync_s),
    .active_o(v_act_s),
    .wrap_o  (v_wrap_s)
  );

  // The axis counters hold the next pixel to present; a step latches it into the outputs
  always_ff @(posedge Clk) begin
    if (Reset || !en) begin
      state_q  <= VGA_IDLE;
      div_q    <= '0;
      drawx_q  <= '0;
      drawy_q  <= '0;
      hs_q     <= HS_NEG;
      vs_q     <= VS_NEG;
      blank_q  <= 1'b1;
      pce_q    <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      origin_q <= 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
      first_q  <= 1'b1;
      if (Reset) begin
        fcnt_q <= 16'd0;
      end
`endif
    end else begin
      case (state_q)
        VGA_IDLE: begin
          state_q <= VGA_RUN;
          div_q   <= '0;
        end
        VGA_RUN: begin
          if (step_s) begin
            div_q    <= '0;
            drawx_q  <= h_count_s;
            drawy_q  <= v_count_s;
            hs_q     <= h_sync_s;
            vs_q     <= v_sync_s;
            blank_q  <= ~(h_act_s & v_act_s);
            pce_q    <= 1'b1;
            ls_q     <= (h_count_s == '0);
            fs_q     <= origin_q;
            origin_q <= h_wrap_s & v_wrap_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (origin_q) begin
              if (first_q) begin
                first_q <= 1'b0;
              end else begin
                fcnt_q <= fcnt_q + 16'd1;
              end
            end
`endif
          end else begin
            div_q <= div_q + DW'(1);
            pce_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
          end
        end
        default: state_q <= VGA_IDLE;
      endcase
    end
  end

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign pixel_ce    = pce_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign frame_cnt   = fcnt_q;
`endif

endmodule
